// File: rtl/sd_cmd_controller_pkg.sv
// ---------------------------------------------------------------------------
// sd_cmd_controller_pkg
// Shared definitions for the SPI-mode SD command controller and its CRC7
// helper: controller state encoding, RESP_TYPE codes, response lengths and
// the CRC7 generator polynomial.
// ---------------------------------------------------------------------------
package sd_cmd_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CRC,
    ST_LOAD,
    ST_SEND,
    ST_WAIT,
    ST_RECV,
    ST_FIN
  } state_t;

  localparam logic [1:0] RT_NONE   = 2'b00;
  localparam logic [1:0] RT_R1     = 2'b01;
  localparam logic [1:0] RT_R7     = 2'b10;
  localparam logic [1:0] RT_R1_ALT = 2'b11;

  localparam int R1_LEN   = 8;
  localparam int R7_LEN   = 40;
  localparam int CRC_BITS = 40;  // frame bits covered by the CRC

  // x^7 + x^3 + 1 with the implicit x^7 term dropped.
  localparam logic [6:0] CRC7_POLY = 7'h09;

  // Value of the receive bit counter when the final response bit is taken.
  function automatic logic [5:0] resp_last(input logic [1:0] rt);
    return (rt == RT_R7) ? 6'(R7_LEN - 1) : 6'(R1_LEN - 1);
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// ---------------------------------------------------------------------------
// sd_crc7
// Serial CRC7 generator (x^7 + x^3 + 1), one bit per clock, MSB first.
// Ports:
//   CLK      clock (posedge)
//   RESET_N  asynchronous active-low reset, clears the CRC
//   CLEAR    synchronous clear, takes priority over EN
//   EN       shift DIN into the CRC this cycle
//   DIN      serial data bit
//   CRC      current CRC remainder
// ---------------------------------------------------------------------------
module sd_crc7
  import sd_cmd_controller_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       CLEAR,
  input  logic       EN,
  input  logic       DIN,
  output logic [6:0] CRC
);

  logic feedback;
  assign feedback = DIN ^ CRC[6];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      CRC <= '0;
    end else if (CLEAR) begin
      CRC <= '0;
    end else if (EN) begin
      CRC <= {CRC[5:0], 1'b0} ^ (feedback ? CRC7_POLY : 7'h00);
    end
  end

endmodule

// File: rtl/sd_cmd_controller.sv
// ---------------------------------------------------------------------------
// sd_cmd_controller
// Runs one SPI-mode SD command transaction: latches the command, computes
// CRC7 serially, hands the 48-bit frame to the command sender, then hunts
// for the card's response start bit and shifts in an R1 or R7/R3 response.
// Ports:
//   CLK, RESET_N          clock (posedge) and async active-low reset
//   START                 single-cycle request, honoured only when idle
//   CMD_INDEX, CMD_ARG    command index / argument
//   RESP_TYPE             00 none, 01 R1, 10 R7/R3, 11 same as 01
//   MISO                  card data out
//   SEND_VALUE            frame presented to the sender's reset value
//   SEND_RESET            one-cycle load strobe to the sender
//   SEND_ENABLE           sender enable, held until SEND_FINISH
//   SEND_FINISH           sender reports frame fully shifted out
//   BUSY                  transaction in progress
//   DONE, TIMEOUT         completion pulse and its no-response flag
//   RESP                  received response, right-aligned
// ---------------------------------------------------------------------------
module sd_cmd_controller
  import sd_cmd_controller_pkg::*;
#(
  parameter int NCR_MAX = 64,
  parameter int RESP_W  = 40
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              START,
  input  logic [5:0]        CMD_INDEX,
  input  logic [31:0]       CMD_ARG,
  input  logic [1:0]        RESP_TYPE,
  input  logic              MISO,
  output logic [47:0]       SEND_VALUE,
  output logic              SEND_RESET,
  output logic              SEND_ENABLE,
  input  logic              SEND_FINISH,
  output logic              BUSY,
  output logic              DONE,
  output logic              TIMEOUT,
  output logic [RESP_W-1:0] RESP
);

  localparam int WAIT_W = (NCR_MAX > 1) ? $clog2(NCR_MAX) : 1;

  state_t            state_reg;
  logic [39:0]       hdr_reg;     // {01, index, argument}, kept for the frame
  logic [39:0]       shift_reg;   // same bits, consumed MSB first by the CRC
  logic [1:0]        rtype_reg;
  logic [5:0]        cnt_reg;     // CRC bit count, reused as RECV bit count
  logic [WAIT_W-1:0] wait_cnt_reg;

  logic       crc_clear;
  logic       crc_en;
  logic [6:0] crc;

  // Clearing on acceptance means the CRC is zero by the first CRC cycle.
  assign crc_clear = (state_reg == ST_IDLE) && START;
  assign crc_en    = (state_reg == ST_CRC) && (cnt_reg != 6'(CRC_BITS));

  sd_crc7 u_crc7 (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .CLEAR   (crc_clear),
    .EN      (crc_en),
    .DIN     (shift_reg[39]),
    .CRC     (crc)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg    <= ST_IDLE;
      hdr_reg      <= '0;
      shift_reg    <= '0;
      rtype_reg    <= RT_NONE;
      cnt_reg      <= '0;
      wait_cnt_reg <= '0;
      SEND_VALUE   <= '1;
      SEND_RESET   <= 1'b0;
      SEND_ENABLE  <= 1'b0;
      BUSY         <= 1'b0;
      DONE         <= 1'b0;
      TIMEOUT      <= 1'b0;
      RESP         <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (START) begin
            hdr_reg   <= {2'b01, CMD_INDEX, CMD_ARG};
            shift_reg <= {2'b01, CMD_INDEX, CMD_ARG};
            rtype_reg <= (RESP_TYPE == RT_R1_ALT) ? RT_R1 : RESP_TYPE;
            cnt_reg   <= '0;
            RESP      <= '0;
            TIMEOUT   <= 1'b0;
            BUSY      <= 1'b1;
            state_reg <= ST_CRC;
          end
        end

        ST_CRC: begin
          // One extra cycle after the last bit lets the CRC register settle
          // before it is folded into the frame.
          if (cnt_reg == 6'(CRC_BITS)) begin
            SEND_VALUE <= {hdr_reg, crc, 1'b1};
            SEND_RESET <= 1'b1;
            state_reg  <= ST_LOAD;
          end else begin
            shift_reg <= shift_reg << 1;
            cnt_reg   <= cnt_reg + 6'd1;
          end
        end

        ST_LOAD: begin
          SEND_RESET  <= 1'b0;
          SEND_ENABLE <= 1'b1;
          state_reg   <= ST_SEND;
        end

        ST_SEND: begin
          if (SEND_FINISH) begin
            SEND_ENABLE  <= 1'b0;
            wait_cnt_reg <= '0;
            if (rtype_reg == RT_NONE) begin
              DONE      <= 1'b1;
              state_reg <= ST_FIN;
            end else begin
              state_reg <= ST_WAIT;
            end
          end
        end

        ST_WAIT: begin
          if (!MISO) begin
            // The start bit is the response MSB, so it is shifted in too.
            RESP      <= {RESP[RESP_W-2:0], MISO};
            cnt_reg   <= 6'd1;
            state_reg <= ST_RECV;
          end else if (wait_cnt_reg == WAIT_W'(NCR_MAX - 1)) begin
            TIMEOUT   <= 1'b1;
            DONE      <= 1'b1;
            state_reg <= ST_FIN;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end

        ST_RECV: begin
          RESP <= {RESP[RESP_W-2:0], MISO};
          if (cnt_reg == resp_last(rtype_reg)) begin
            DONE      <= 1'b1;
            state_reg <= ST_FIN;
          end else begin
            cnt_reg <= cnt_reg + 6'd1;
          end
        end

        ST_FIN: begin
          DONE      <= 1'b0;
          BUSY      <= 1'b0;
          state_reg <= ST_IDLE;
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_controller.sv
// ---------------------------------------------------------------------------
// tb_sd_cmd_controller
// Self-checking bench for sd_cmd_controller. The bench plays both the
// command sender (SEND_FINISH) and the card (MISO); expected frames come
// from CRC7 computed by polynomial long division, expected responses and
// completion timing from the response rules.
// ---------------------------------------------------------------------------
module tb_sd_cmd_controller;

  localparam int NCR_MAX = 64;
  localparam int RESP_W  = 40;

  logic              CLK = 1'b0;
  logic              RESET_N = 1'b0;
  logic              START = 1'b0;
  logic [5:0]        CMD_INDEX = '0;
  logic [31:0]       CMD_ARG = '0;
  logic [1:0]        RESP_TYPE = '0;
  logic              MISO = 1'b1;
  logic [47:0]       SEND_VALUE;
  logic              SEND_RESET;
  logic              SEND_ENABLE;
  logic              SEND_FINISH = 1'b0;
  logic              BUSY;
  logic              DONE;
  logic              TIMEOUT;
  logic [RESP_W-1:0] RESP;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  sd_cmd_controller #(.NCR_MAX(NCR_MAX), .RESP_W(RESP_W)) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .START       (START),
    .CMD_INDEX   (CMD_INDEX),
    .CMD_ARG     (CMD_ARG),
    .RESP_TYPE   (RESP_TYPE),
    .MISO        (MISO),
    .SEND_VALUE  (SEND_VALUE),
    .SEND_RESET  (SEND_RESET),
    .SEND_ENABLE (SEND_ENABLE),
    .SEND_FINISH (SEND_FINISH),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .TIMEOUT     (TIMEOUT),
    .RESP        (RESP)
  );

  // Remainder of msg(x) * x^7 divided by x^7 + x^3 + 1.
  function automatic logic [6:0] ref_crc7(input logic [39:0] msg);
    logic [46:0] v;
    v = {msg, 7'd0};
    for (int i = 46; i >= 7; i--)
      if (v[i]) v = v ^ (47'h89 << (i - 7));
    return v[6:0];
  endfunction

  function automatic logic [47:0] ref_frame(input logic [5:0] idx, input logic [31:0] arg);
    return {2'b01, idx, arg, ref_crc7({2'b01, idx, arg}), 1'b1};
  endfunction

  // One full transaction, entered and left on a negedge with BUSY low.
  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg,
                         input logic [1:0] rt, input logic [39:0] rv,
                         input int delay, input int send_len, input bit junk,
                         input string tag);
    int len, exp_done_at, done_at, guard;
    bit exp_to;
    logic [39:0] exp_resp;
    logic [47:0] exp_frame;
    len         = (rt == 2'b00) ? 0 : (rt == 2'b10) ? 40 : 8;
    exp_frame   = ref_frame(idx, arg);
    exp_to      = (len != 0) && (delay >= NCR_MAX);
    exp_resp    = (len == 0 || exp_to) ? 40'd0 : (len == 40) ? rv : {32'd0, rv[7:0]};
    exp_done_at = (len == 0) ? 0 : exp_to ? NCR_MAX : delay + len;

    START = 1'b1; CMD_INDEX = idx; CMD_ARG = arg; RESP_TYPE = rt;
    @(negedge CLK);
    START = 1'b0; CMD_INDEX = 6'($urandom); CMD_ARG = $urandom; RESP_TYPE = 2'($urandom);
    n_cmp++;
    if (BUSY !== 1'b1 || RESP !== '0) begin
      n_bad++;
      $display("FAIL %s accept: BUSY=%b RESP=%h, required BUSY=1 RESP=0", tag, BUSY, RESP);
    end

    guard = 0;
    while (SEND_RESET !== 1'b1 && guard < 100) begin
      if (junk && guard == 5) START = 1'b1;
      if (junk && guard == 6) START = 1'b0;
      @(negedge CLK);
      guard++;
    end
    START = 1'b0;
    n_cmp++;
    if (guard >= 100) begin
      n_bad++;
      $display("FAIL %s load: SEND_RESET never rose within 100 cycles", tag);
      return;
    end
    if (SEND_VALUE !== exp_frame) begin
      n_bad++;
      $display("FAIL %s frame: SEND_VALUE=%h required %h", tag, SEND_VALUE, exp_frame);
    end

    @(negedge CLK);
    n_cmp++;
    if (SEND_RESET !== 1'b0 || SEND_ENABLE !== 1'b1) begin
      n_bad++;
      $display("FAIL %s load_pulse: SEND_RESET=%b SEND_ENABLE=%b required 0/1", tag, SEND_RESET, SEND_ENABLE);
    end

    // Sender busy for send_len cycles; card noise on MISO must be ignored.
    for (int k = 1; k < send_len; k++) begin
      MISO = 1'($urandom);
      @(negedge CLK);
    end
    SEND_FINISH = 1'b1;
    MISO = 1'b1;
    @(negedge CLK);
    SEND_FINISH = 1'b0;
    n_cmp++;
    if (SEND_ENABLE !== 1'b0) begin
      n_bad++;
      $display("FAIL %s enable_drop: SEND_ENABLE=%b required 0", tag, SEND_ENABLE);
    end

    // Card side: delay ones, then the response MSB first, one bit per cycle.
    done_at = -1;
    for (int i = 0; i < 200; i++) begin
      if (DONE === 1'b1) begin
        done_at = i;
        break;
      end
      if (len == 0)                MISO = 1'($urandom);
      else if (i < delay)          MISO = 1'b1;
      else if (i < delay + len)    MISO = rv[len - 1 - (i - delay)];
      else                         MISO = 1'b1;
      @(negedge CLK);
    end
    MISO = 1'b1;
    n_cmp++;
    if (done_at != exp_done_at) begin
      n_bad++;
      $display("FAIL %s done_time: DONE after %0d cycles, required %0d", tag, done_at, exp_done_at);
    end
    if (done_at < 0) return;
    n_cmp++;
    if (TIMEOUT !== exp_to || RESP !== exp_resp) begin
      n_bad++;
      $display("FAIL %s result: TIMEOUT=%b RESP=%h required TIMEOUT=%b RESP=%h",
               tag, TIMEOUT, RESP, exp_to, exp_resp);
    end

    // START coinciding with DONE must be ignored.
    if (junk) begin
      START = 1'b1; CMD_INDEX = 6'($urandom); RESP_TYPE = 2'b01;
    end
    @(negedge CLK);
    START = 1'b0;
    n_cmp++;
    if (DONE !== 1'b0 || BUSY !== 1'b0 || RESP !== exp_resp) begin
      n_bad++;
      $display("FAIL %s finish: DONE=%b BUSY=%b RESP=%h required 0/0/%h", tag, DONE, BUSY, RESP, exp_resp);
    end
    $display("txn %s idx=%0d arg=%h rt=%b frame=%h resp=%h timeout=%b done_at=%0d",
             tag, idx, arg, rt, SEND_VALUE, RESP, TIMEOUT, done_at);
  endtask

  task automatic test_reset;
    RESET_N = 1'b0;
    repeat (2) @(negedge CLK);
    n_cmp++;
    if (SEND_VALUE !== 48'hFFFF_FFFF_FFFF || SEND_RESET !== 1'b0 || SEND_ENABLE !== 1'b0 ||
        BUSY !== 1'b0 || DONE !== 1'b0 || TIMEOUT !== 1'b0 || RESP !== '0) begin
      n_bad++;
      $display("FAIL reset: SV=%h SR=%b SE=%b BUSY=%b DONE=%b TO=%b RESP=%h required FFFFFFFFFFFF/0/0/0/0/0/0",
               SEND_VALUE, SEND_RESET, SEND_ENABLE, BUSY, DONE, TIMEOUT, RESP);
    end
    RESET_N = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_cmd0;
    run_cmd(6'd0, 32'd0, 2'b01, 40'h01, 3, 48, 1'b0, "cmd0");
    n_cmp++;
    if (SEND_VALUE !== 48'h4000_0000_0095) begin
      n_bad++;
      $display("FAIL cmd0_const: SEND_VALUE=%h required 400000000095", SEND_VALUE);
    end
  endtask

  task automatic test_cmd8;
    run_cmd(6'd8, 32'h1AA, 2'b10, 40'h01_0000_01AA, 2, 48, 1'b0, "cmd8");
    n_cmp++;
    if (SEND_VALUE !== 48'h4800_0001_AA87 || RESP !== 40'h01_0000_01AA) begin
      n_bad++;
      $display("FAIL cmd8_const: SEND_VALUE=%h RESP=%h required 48000001AA87 / 01000001AA", SEND_VALUE, RESP);
    end
  endtask

  task automatic test_timeout;
    run_cmd(6'd55, 32'd0, 2'b01, 40'h01, 1000, 48, 1'b0, "cmd55_timeout");
  endtask

  task automatic test_no_resp;
    run_cmd(6'($urandom), $urandom, 2'b00, 40'd0, 0, 10, 1'b0, "no_resp");
  endtask

  task automatic test_back_to_back;
    run_cmd(6'd17, 32'h0000_0200, 2'b01, 40'h00, 5, 20, 1'b1, "b2b_first");
    run_cmd(6'd58, 32'h0, 2'b10, 40'h00FF_8000_00, 0, 30, 1'b0, "b2b_second");
    repeat (3) @(negedge CLK);
    n_cmp++;
    if (BUSY !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_idle: BUSY=%b required 0", BUSY);
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 10; n++) begin
      logic [1:0]  rt;
      logic [39:0] rv;
      rt = 2'($urandom);
      rv = {8'($urandom), $urandom};
      if (rt == 2'b10) rv[39] = 1'b0;
      else             rv[7]  = 1'b0;
      run_cmd(6'($urandom), $urandom, rt, rv, $urandom_range(0, 70),
              $urandom_range(1, 48), 1'($urandom), $sformatf("rand%0d", n));
    end
  endtask

  task automatic test_reset_mid_send;
    int guard;
    START = 1'b1; CMD_INDEX = 6'd24; CMD_ARG = 32'h1234_5678; RESP_TYPE = 2'b01;
    @(negedge CLK);
    START = 1'b0;
    guard = 0;
    while (SEND_ENABLE !== 1'b1 && guard < 100) begin
      @(negedge CLK);
      guard++;
    end
    #2 RESET_N = 1'b0;
    #1;
    n_cmp++;
    if (guard >= 100 || SEND_VALUE !== 48'hFFFF_FFFF_FFFF || SEND_RESET !== 1'b0 ||
        SEND_ENABLE !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0 || TIMEOUT !== 1'b0 || RESP !== '0) begin
      n_bad++;
      $display("FAIL mid_send_reset: guard=%0d SV=%h SE=%b BUSY=%b RESP=%h required reset values",
               guard, SEND_VALUE, SEND_ENABLE, BUSY, RESP);
    end
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    run_cmd(6'd0, 32'd0, 2'b01, 40'h01, 3, 48, 1'b0, "cmd0_after_reset");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_cmd0;
    test_cmd8;
    test_timeout;
    test_no_resp;
    test_back_to_back;
    test_random;
    test_reset_mid_send;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
